// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier feeder:
//   OPW      - operand width presented to the multiplier
//   PW       - product width returned by the multiplier
//   state_t  - feeder FSM state encoding
//   is_waiting() - true while the feeder is waiting on the multiplier
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  // Both wait states count towards the timeout window.
  function automatic logic is_waiting(input state_t s);
    return (s == WAIT_BUSY) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/mult_timeout.sv
// -----------------------------------------------------------------------------
// mult_timeout
// Cycle counter that flags when the feeder has been waiting on the multiplier
// for LIMIT consecutive cycles. Only exists in builds with
// MULT_FEEDER_TIMEOUT_EN defined.
//
// Ports:
//   clock   - system clock, rising edge
//   n_reset - asynchronous active-low reset, clears the count
//   run     - high in every cycle spent waiting; low clears the count
//   expired - high in the LIMIT-th consecutive cycle of run
// -----------------------------------------------------------------------------
`ifdef MULT_FEEDER_TIMEOUT_EN
module mult_timeout #(
  parameter int LIMIT = 32
) (
  input  logic clock,
  input  logic n_reset,
  input  logic run,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] count;

  // count holds the number of completed waiting cycles, so it reads LIMIT-1
  // during the LIMIT-th one.
  assign expired = run && (count == CW'(LIMIT - 1));

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (!run || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/mult_feeder.sv
// -----------------------------------------------------------------------------
// mult_feeder
// Feeds one operand pair at a time into an external START/READY multiplier and
// holds the product on a valid/ready output until it is taken. No operand
// buffering: the block accepts a new pair only when idle.
//
// Build option: define MULT_FEEDER_TIMEOUT_EN to add a wait timeout. When the
// multiplier has not finished within TIMEOUT_CYCLES waiting cycles, the block
// returns 8'hFF, raises the sticky timeout_err output and moves on.
//
// Parameters:
//   TIMEOUT_CYCLES - waiting cycles allowed before a timeout (timeout build)
// Ports:
//   clock, n_reset        - clock (rising edge), async active-low reset
//   in_valid/in_ready     - upstream handshake for the pair in_a, in_b
//   mult_a, mult_b        - operands held steady for the multiplier
//   START                 - one-cycle start pulse to the multiplier
//   READY, AQ             - multiplier idle/done flag and product
//   out_valid/out_ready   - downstream handshake for out_data
//   timeout_err           - sticky timeout flag (timeout build only)
// -----------------------------------------------------------------------------
module mult_feeder
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic [OPW-1:0] mult_a,
  output logic [OPW-1:0] mult_b,
  output logic           START,
  input  logic           READY,
  input  logic [PW-1:0]  AQ,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  out_data
`ifdef MULT_FEEDER_TIMEOUT_EN
  ,
  output logic           timeout_err
`endif
);

  // A zero-cycle timeout window is meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mult_feeder: TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;
  state_t state_nx;
  logic   ready_hi;     // READY was already high in the previous WAIT_BUSY cycle
  logic   accept;
  logic   capture;
  logic   timeout_hit;
  logic   expired;

  // Moore outputs decoded from the state register; all are inactive in IDLE,
  // so reset (and its release) can never produce a START pulse.
  assign in_ready  = (state == IDLE);
  assign START     = (state == LAUNCH);
  assign out_valid = (state == HOLD);

`ifdef MULT_FEEDER_TIMEOUT_EN
  mult_timeout #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .n_reset (n_reset),
    .run     (is_waiting(state)),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A multiplier that never shows busy is taken as already finished
        // once READY has been seen high on two consecutive edges.
        if (!READY) begin
          state_nx = WAIT_DONE;
        end else if (ready_hi) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      WAIT_DONE: begin
        // The first sampled high wins; any later drop of READY is ignored
        // because we have already left this state.
        if (READY) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // A genuine completion in the same cycle as expiry takes precedence.
    if (expired && !capture && is_waiting(state)) begin
      timeout_hit = 1'b1;
      state_nx    = HOLD;
    end
  end

  // State and operand/result registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      ready_hi <= 1'b0;
      mult_a   <= '0;
      mult_b   <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nx;
      ready_hi <= (state == WAIT_BUSY) && READY;
      if (accept) begin
        mult_a <= in_a;
        mult_b <= in_b;
      end
      if (capture) begin
        out_data <= AQ;
      end else if (timeout_hit) begin
        out_data <= '1;
      end
    end
  end

`ifdef MULT_FEEDER_TIMEOUT_EN
  // Sticky until the next operand pair is accepted.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      timeout_err <= 1'b0;
    end else if (accept) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_feeder.sv
// -----------------------------------------------------------------------------
// tb_mult_feeder
// Self-checking bench for mult_feeder with a behavioural START/READY
// multiplier. Inputs are driven and outputs sampled on the falling clock edge.
// Define MULT_FEEDER_TIMEOUT_EN to include the timeout scenario.
// -----------------------------------------------------------------------------
module tb_mult_feeder;

  localparam int TO = 32;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic [3:0] mult_a;
  logic [3:0] mult_b;
  logic       START;
  logic       READY = 1'b1;
  logic [7:0] AQ = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
`ifdef MULT_FEEDER_TIMEOUT_EN
  logic       timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mult_feeder #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .START       (START),
    .READY       (READY),
    .AQ          (AQ),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef MULT_FEEDER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  // Behavioural multiplier: on START it drops READY for mdl_busy cycles with
  // junk on AQ, then raises READY with the product. mdl_busy == 0 models a
  // multiplier that never shows busy; mdl_stuck freezes it busy.
  int         mdl_busy  = 8;
  bit         mdl_stuck = 1'b0;
  int         mdl_cnt   = 0;
  int         n_starts  = 0;
  logic [7:0] mdl_prod  = 8'd0;

  always @(negedge clock) begin
    if (!n_reset) begin
      READY   = 1'b1;
      mdl_cnt = 0;
    end else if (START) begin
      n_starts++;
      mdl_prod = {4'd0, mult_a} * {4'd0, mult_b};
      mdl_cnt  = mdl_busy;
      if (mdl_busy == 0) begin
        READY = 1'b1;
        AQ    = mdl_prod;
      end else begin
        READY = 1'b0;
        AQ    = 8'($urandom);
      end
    end else if (!READY && !mdl_stuck) begin
      mdl_cnt--;
      if (mdl_cnt <= 0) begin
        READY = 1'b1;
        AQ    = mdl_prod;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Falling edges from driving in_valid to the first out_valid: the accept
  // edge, one LAUNCH cycle, then the wait. A real busy period of N>=2 cycles
  // ends one cycle after READY returns; a multiplier that never looks busy is
  // captured after two high samples; a stuck one after the timeout window.
  function automatic int exp_latency(input int busy, input bit stuck);
    if (stuck) return 2 + TO;
    if (busy <= 1) return 4;
    return 2 + busy;
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int busy,
                        input int hold, input logic [7:0] exp, input int exp_lat,
                        input string tag);
    int         lat;
    int         s0;
    bit         busy_ok;
    bit         hold_ok;
    logic [7:0] d0;
    mdl_busy = busy;
    s0       = n_starts;
    check({tag, " in_ready idle"}, in_ready, 1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    check({tag, " START one cycle after accept"}, START, 1);
    check({tag, " in_ready after accept"}, in_ready, 0);
`ifdef MULT_FEEDER_TIMEOUT_EN
    check({tag, " timeout_err cleared by accept"}, timeout_err, 0);
`endif
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
      if (START || in_ready || mult_a !== a || mult_b !== b) busy_ok = 1'b0;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " out_data"}, out_data, exp);
`ifdef MULT_FEEDER_TIMEOUT_EN
    check({tag, " timeout_err"}, timeout_err, mdl_stuck);
`endif
    d0      = out_data;
    hold_ok = 1'b1;
    repeat (hold) begin
      @(negedge clock);
      if (!out_valid || out_data !== d0 || in_ready || START ||
          mult_a !== a || mult_b !== b) hold_ok = 1'b0;
    end
    check({tag, " stable while out_ready low"}, hold_ok, 1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, " out_valid drops after take"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
    check({tag, " busy phase clean"}, busy_ok, 1);
    check({tag, " one START"}, n_starts - s0, 1);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         busy;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'd3,  4'd5,  8, 3,  8'h0F};
    tbl[1] = '{4'd15, 4'd15, 8, 0,  8'hE1};
    tbl[2] = '{4'd0,  4'd7,  8, 0,  8'h00};
    tbl[3] = '{4'd7,  4'd0,  2, 0,  8'h00};
    tbl[4] = '{4'd15, 4'd15, 0, 2,  8'hE1};
    tbl[5] = '{4'd9,  4'd9,  5, 1,  8'h51};
    tbl[6] = '{4'd1,  4'd1,  3, 0,  8'h01};
    tbl[7] = '{4'd6,  4'd7,  8, 10, 8'h2A};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset START", START, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset mult_a", mult_a, 0);
    check("reset mult_b", mult_b, 0);
    check("reset in_ready", in_ready, 1);
`ifdef MULT_FEEDER_TIMEOUT_EN
    check("reset timeout_err", timeout_err, 0);
`endif
    n_reset = 1'b1;
    @(negedge clock);
    check("no START on reset release", START, 0);
    @(negedge clock);
    check("no START after reset release", START, 0);
    check("no spurious START count", n_starts, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].busy, tbl[i].hold, tbl[i].exp,
             exp_latency(tbl[i].busy, 1'b0), $sformatf("vec%0d", i));
    end

    // Reset in the middle of WAIT_DONE discards the operation
    mdl_busy = 8;
    in_a     = 4'd5;
    in_b     = 4'd6;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    n_reset = 1'b0;
    #1;
    check("midop reset START", START, 0);
    check("midop reset out_valid", out_valid, 0);
    check("midop reset out_data", out_data, 0);
    check("midop reset mult_a", mult_a, 0);
    check("midop reset mult_b", mult_b, 0);
    @(negedge clock);
    @(negedge clock);
    n_reset = 1'b1;
    begin
      bit quiet = 1'b1;
      repeat (12) begin
        @(negedge clock);
        if (START || out_valid || !in_ready) quiet = 1'b0;
      end
      check("discarded op stays silent", quiet, 1);
    end
    run_op(4'd2, 4'd2, 8, 0, 8'h04, exp_latency(8, 1'b0), "post_reset");

    // Randomised operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      int         rbusy;
      int         prod;
      ra    = 4'($urandom);
      rb    = 4'($urandom);
      rbusy = $urandom_range(0, 10);
      if (rbusy == 1) rbusy = 0;
      prod  = ra * rb;
      run_op(ra, rb, rbusy, $urandom_range(0, 3), 8'(prod),
             exp_latency(rbusy, 1'b0), $sformatf("rnd%0d", i));
    end

`ifdef MULT_FEEDER_TIMEOUT_EN
    // Multiplier stuck busy
    mdl_stuck = 1'b1;
    run_op(4'd3, 4'd3, 8, 0, 8'hFF, exp_latency(8, 1'b1), "timeout");
    check("timeout_err sticky in idle", timeout_err, 1);
    mdl_stuck = 1'b0;
    run_op(4'd2, 4'd3, 4, 0, 8'h06, exp_latency(4, 1'b0), "after_timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_feeder.md
MULT_FEEDER -- requirements
Module: mult_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32, meaning the maximum cycles spent waiting on multiplier READY before an error is flagged.
REQ-002 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream operand pair valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have ports in_a and in_b, input, 4 each, unsigned operands.
REQ-007 SHALL have ports mult_a and mult_b, output, 4 each, operands presented to the multiplier.
REQ-008 SHALL have port START, output, 1, start pulse to the multiplier.
REQ-009 SHALL have port READY, input, 1, multiplier idle with a valid AQ (low while busy).
REQ-010 SHALL have port AQ, input, 8, multiplier product.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 8), the downstream result handshake.
REQ-012 SHALL have port timeout_err, output, 1, sticky error flag; present only when MULT_FEEDER_TIMEOUT_EN is defined.

Function
REQ-013 SHALL implement the FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and HOLD.
REQ-014 In IDLE: in_ready=1; on in_valid, latch in_a/in_b into mult_a/mult_b and go to LAUNCH.
REQ-015 In LAUNCH: assert START for exactly one cycle, then go to WAIT_BUSY.
REQ-016 In WAIT_BUSY: go to WAIT_DONE on READY=0; if READY stays high for 2 cycles, treat the operation as already complete and capture AQ as in WAIT_DONE.
REQ-017 In WAIT_DONE: on READY=1, capture AQ into out_data and go to HOLD.
REQ-018 In HOLD: out_valid=1 and out_data stable; on out_ready=1 go to IDLE.
REQ-019 Latency SHALL be: accept to START = 1 cycle; READY rise to out_valid = 1 cycle.
REQ-020 mult_a/mult_b SHALL be held constant from LAUNCH until return to IDLE.
REQ-021 in_ready SHALL be 0 in every state other than IDLE; no operand buffering.
REQ-022 A READY glitch (high then low) during WAIT_DONE SHALL only be acted on at the first sampled high.
REQ-023 A zero operand SHALL pass through unchanged; out_data equals AQ with no arithmetic in this block.

Reset
REQ-024 On n_reset=0, asynchronously: state=IDLE, START=0, out_valid=0, out_data=0, mult_a=mult_b=0, timeout_err=0, timeout counter=0.
REQ-025 Reset mid-operation SHALL discard the operation silently; the first post-reset accept SHALL start cleanly.
REQ-026 START SHALL never be asserted in the cycle of reset deassertion.

Configuration
REQ-027 With MULT_FEEDER_TIMEOUT_EN defined: a counter runs in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT_CYCLES it sets timeout_err, sets out_data=8'hFF and goes to HOLD; timeout_err clears on the next accepted in_valid.
REQ-028 Without MULT_FEEDER_TIMEOUT_EN: no counter, no timeout_err port; WAIT_DONE waits indefinitely.

Structure
REQ-029 The FSM state enum and the widths OPW=4 and PW=8 SHALL live in the shared package mult_pkg.
REQ-030 The timeout counter SHALL be the sub-module mult_timeout, instantiated only under MULT_FEEDER_TIMEOUT_EN.

Verification
REQ-031 Reset then in 3x5 with a model multiplier (READY low 8 cycles) -> one START pulse; out_data=8'h0F; out_valid held until out_ready.
REQ-032 Back-to-back pairs 15x15 and 0x7 -> results 8'hE1 then 8'h00; in_ready=0 throughout each operation.
REQ-033 out_ready held low 10 cycles -> out_valid and out_data stable; in_ready=0; no second START.
REQ-034 n_reset pulsed low during WAIT_DONE -> all outputs 0 immediately; next pair 2x2 -> 8'h04.
REQ-035 With MULT_FEEDER_TIMEOUT_EN, READY stuck low -> after 32 cycles timeout_err=1 and out_data=8'hFF; next accept clears timeout_err.
REQ-036 Multiplier that never drops READY -> capture after 2 cycles in WAIT_BUSY; out_valid asserted.
